// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU. Holds the 4-bit
//               op-code constants, the controller state type and small
//               op-code classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Op-code map. Any code not listed here executes as an add.
    localparam logic [3:0] c_op_and   = 4'b0000;
    localparam logic [3:0] c_op_or    = 4'b0001;
    localparam logic [3:0] c_op_add   = 4'b0010;
    localparam logic [3:0] c_op_sltu  = 4'b0011;
    localparam logic [3:0] c_op_sub   = 4'b0110;
    localparam logic [3:0] c_op_slt   = 4'b0111;
    localparam logic [3:0] c_op_mult  = 4'b1000;
    localparam logic [3:0] c_op_multu = 4'b1001;
    localparam logic [3:0] c_op_div   = 4'b1010;
    localparam logic [3:0] c_op_divu  = 4'b1011;
    localparam logic [3:0] c_op_nor   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // The iterative ops occupy the 10xx block: bit 1 selects divide,
    // bit 0 selects the unsigned variant.
    function automatic logic is_muldiv_op(input logic [3:0] code);
        return (code[3:2] == 2'b10);
    endfunction

    function automatic logic is_div_op(input logic [3:0] code);
        return (code[3:2] == 2'b10) && code[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv
// Description : Iterative multiply / divide datapath, one bit per cycle.
//               Signed operands are converted to magnitudes on load, the
//               unsigned core iterates WIDTH times, and the signs are
//               re-applied on the way out.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   i_start   : load operands and begin (ignored while iterating is the
//               caller's responsibility)
//   i_signed  : operands are two's complement
//   i_div     : 1 = restoring divide, 0 = shift-add multiply
//   i_a, i_b  : multiplicand/dividend, multiplier/divisor (divisor != 0)
//   o_hi,o_lo : product high/low, or remainder/quotient; valid with o_finish
//   o_finish  : high during the cycle whose rising edge performs the final
//               iteration; o_hi/o_lo then show the post-iteration result
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_finish
);

    localparam int                c_cntw     = $clog2(WIDTH + 1);
    localparam logic [c_cntw-1:0] c_cnt_load = c_cntw'(WIDTH);
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(1);

    logic              r_active;
    logic              r_div;
    logic              r_neg_q;   // negate product (mul) or quotient (div)
    logic              r_neg_r;   // negate remainder (div only)
    logic [c_cntw-1:0] r_cnt;
    logic [WIDTH-1:0]  r_hi;      // product high / partial remainder
    logic [WIDTH-1:0]  r_lo;      // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0]  r_b;       // multiplicand / divisor magnitude

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Magnitudes; the most-negative value maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign w_abs_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // Shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the {hi, lo} pair right with the carry entering hi.
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Restoring step: the partial remainder is always below the divisor, so
    // the shifted value is below twice the divisor and the trial difference
    // fits in WIDTH+1 bits with its MSB acting as the borrow.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_b};
    assign w_ge    = ~w_trial[WIDTH];

    always_comb begin
        w_it_hi = r_hi;
        w_it_lo = r_lo;
        if (r_div) begin
            w_it_hi = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_it_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_it_hi = w_madd[WIDTH:1];
            w_it_lo = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    assign w_prod     = {w_it_hi, w_it_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    assign o_hi     = r_div ? (r_neg_r ? -w_it_hi : w_it_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
    assign o_lo     = r_div ? (r_neg_q ? -w_it_lo : w_it_lo) : w_prod_fix[WIDTH-1:0];
    assign o_finish = r_active && (r_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_div    <= i_div;
            r_neg_q  <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed && i_a[WIDTH-1];
            r_cnt    <= c_cnt_load;
            r_hi     <= '0;
            r_lo     <= w_abs_a;
            r_b      <= w_abs_b;
        end else if (r_active) begin
            r_hi  <= w_it_hi;
            r_lo  <= w_it_lo;
            r_cnt <= r_cnt - c_cnt_last;
            if (r_cnt == c_cnt_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU. Logic/arith/compare ops complete in one
//               cycle; multiply and divide run WIDTH iterations in
//               seq_muldiv. Results and flags are registered and held
//               between done pulses.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : request strobe (ignored while busy or done)
//   op           : operation code (low 4 bits decoded, OPW >= 4)
//   data0, data1 : operands A and B
//   aluRes       : result / product low / quotient
//   aluHi        : product high / remainder, 0 for single-cycle ops
//   zero         : aluRes == 0
//   ovf          : signed overflow of add/sub
//   divz         : last op was a divide by zero
//   busy         : iterative operation in progress
//   done         : one-cycle pulse, outputs valid
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] aluRes,
    output logic [WIDTH-1:0] aluHi,
    output logic             zero,
    output logic             ovf,
    output logic             divz,
    output logic             busy,
    output logic             done
);

    alu_state_t       r_state;
    logic [WIDTH-1:0] r_alu_res;
    logic [WIDTH-1:0] r_alu_hi;
    logic             r_ovf;
    logic             r_divz;

    alu_state_t       w_state_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic             w_ovf_nxt;
    logic             w_divz_nxt;

    logic [3:0]       w_code;
    logic             w_is_md;
    logic             w_is_div;
    logic             w_md_start;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic             w_md_finish;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_single_res;
    logic             w_single_ovf;

    // Codes with any bit set above the 4-bit map are unknown and run as add.
    assign w_code   = ((op >> 4) == '0) ? op[3:0] : c_op_add;
    assign w_is_md  = is_muldiv_op(w_code);
    assign w_is_div = is_div_op(w_code);

    assign w_sum     = data0 + data1;
    assign w_diff    = data0 - data1;
    assign w_add_ovf = (data0[WIDTH-1] == data1[WIDTH-1]) && (w_sum[WIDTH-1]  != data0[WIDTH-1]);
    assign w_sub_ovf = (data0[WIDTH-1] != data1[WIDTH-1]) && (w_diff[WIDTH-1] != data0[WIDTH-1]);

    always_comb begin
        w_single_res = w_sum;
        w_single_ovf = w_add_ovf;
        case (w_code)
            c_op_and: begin
                w_single_res = data0 & data1;
                w_single_ovf = 1'b0;
            end
            c_op_or: begin
                w_single_res = data0 | data1;
                w_single_ovf = 1'b0;
            end
            c_op_nor: begin
                w_single_res = ~(data0 | data1);
                w_single_ovf = 1'b0;
            end
            c_op_sub: begin
                w_single_res = w_diff;
                w_single_ovf = w_sub_ovf;
            end
            c_op_slt: begin
                w_single_res = {{(WIDTH-1){1'b0}}, ($signed(data0) < $signed(data1))};
                w_single_ovf = 1'b0;
            end
            c_op_sltu: begin
                w_single_res = {{(WIDTH-1){1'b0}}, (data0 < data1)};
                w_single_ovf = 1'b0;
            end
            default: begin
                w_single_res = w_sum;
                w_single_ovf = w_add_ovf;
            end
        endcase
    end

    // Controller: next state and next values of the held output registers.
    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_alu_res;
        w_hi_nxt    = r_alu_hi;
        w_ovf_nxt   = r_ovf;
        w_divz_nxt  = r_divz;
        w_md_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_div && (data1 == '0)) begin
                        // Divide by zero short-circuits the iteration.
                        w_res_nxt   = '1;
                        w_hi_nxt    = data0;
                        w_ovf_nxt   = 1'b0;
                        w_divz_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (w_is_md) begin
                        w_md_start  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_res_nxt   = w_single_res;
                        w_hi_nxt    = '0;
                        w_ovf_nxt   = w_single_ovf;
                        w_divz_nxt  = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // Outputs stay frozen until the final iteration edge.
                if (w_md_finish) begin
                    w_res_nxt   = w_md_lo;
                    w_hi_nxt    = w_md_hi;
                    w_ovf_nxt   = 1'b0;
                    w_divz_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_alu_res <= '0;
            r_alu_hi  <= '0;
            r_ovf     <= 1'b0;
            r_divz    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_alu_res <= w_res_nxt;
            r_alu_hi  <= w_hi_nxt;
            r_ovf     <= w_ovf_nxt;
            r_divz    <= w_divz_nxt;
        end
    end

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (reset),
        .i_start  (w_md_start),
        .i_signed (~w_code[0]),
        .i_div    (w_is_div),
        .i_a      (data0),
        .i_b      (data1),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo),
        .o_finish (w_md_finish)
    );

    assign aluRes = r_alu_res;
    assign aluHi  = r_alu_hi;
    assign zero   = (r_alu_res == '0);
    assign ovf    = r_ovf;
    assign divz   = r_divz;
    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (min 8).
REQ-002 SHALL have parameter OPW, default 4, op-code width.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 start  input  1  request strobe; sampled each edge.
REQ-006 op  input  OPW  operation code, sampled with start.
REQ-007 data0  input  WIDTH  operand A, sampled with start.
REQ-008 data1  input  WIDTH  operand B, sampled with start.
REQ-009 aluRes  output  WIDTH  result / product low / quotient.
REQ-010 aluHi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
REQ-011 zero  output  1  aluRes == 0.
REQ-012 ovf  output  1  signed overflow (add/sub only), else 0.
REQ-013 divz  output  1  last op was a divide by zero.
REQ-014 busy  output  1  operation in progress; start ignored.
REQ-015 done  output  1  one-cycle pulse, outputs valid.

Function
REQ-016 Op codes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (signed), 0011 sltu, 1100 nor, 1000 mult, 1001 multu, 1010 div, 1011 divu; any other code SHALL behave as add.
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE + start + single-cycle op: compute, register outputs, go DONE; done high the cycle after the accepting edge (latency 1).
REQ-019 IDLE + start + mult/multu/div/divu (divisor != 0): latch operands, go RUN, busy = 1 from next cycle.
REQ-020 RUN SHALL iterate exactly WIDTH cycles (shift-add multiply, restoring divide, one bit per cycle), then go DONE; done asserts WIDTH+1 cycles after the accepting edge.
REQ-021 DONE SHALL last one cycle (done = 1, busy = 0), then return to IDLE.
REQ-022 start while busy or in DONE SHALL be ignored, with no effect on outputs or state.
REQ-023 aluRes/aluHi/flags SHALL hold their values from the last done until the next done; they SHALL not change mid-RUN.
REQ-024 Add/sub wrap modulo 2^WIDTH; ovf = operand signs equal (add) or differ (sub) and result sign differs from data0.
REQ-025 mult/multu: {aluHi, aluRes} = full 2*WIDTH product, signed or unsigned.
REQ-026 Signed div: quotient truncated toward zero; remainder takes dividend's sign; most-negative / -1 gives aluRes = most-negative, aluHi = 0, ovf = 0.
REQ-027 Divide by zero: no RUN; DONE after 1 cycle, aluRes = all ones, aluHi = data0, divz = 1.
REQ-028 divz SHALL clear on the next accepted non-zero-divisor divide or any other accepted op.
REQ-029 zero SHALL be computed from registered aluRes only, never left undefined.

Reset
REQ-030 Reset asserted SHALL immediately force IDLE, busy = 0, done = 0, aluRes = 0, aluHi = 0, zero = 1, ovf = 0, divz = 0.
REQ-031 Reset mid-RUN SHALL abandon the operation with no done pulse; first edge after release SHALL accept start normally.

Structure
REQ-032 Shared package alu_pkg SHALL hold op-code constants and the FSM state type.
REQ-033 Iterative multiply/divide datapath SHALL be sub-module seq_muldiv (operands, signed flag, mode, start in; hi, lo, finish out).
REQ-034 Single-cycle ops SHALL remain combinational in seq_alu, feeding the output registers.

Verification (WIDTH = 32)
REQ-035 add 0x7FFFFFFF + 0x00000001 -> done next cycle, aluRes 0x80000000, ovf 1, zero 0.
REQ-036 sub 5 - 5 -> aluRes 0, zero 1; slt 0xFFFFFFFF,1 -> 1; sltu same operands -> 0.
REQ-037 mult -3 * 7 -> done exactly 33 cycles after start, aluHi 0xFFFFFFFF, aluRes 0xFFFFFFEB; start pulsed at cycle 10 ignored.
REQ-038 divu 100 / 7 -> aluRes 14, aluHi 2; div -7 / 2 -> aluRes 0xFFFFFFFD, aluHi 0xFFFFFFFF.
REQ-039 divu 9 / 0 -> done after 1 cycle, aluRes 0xFFFFFFFF, aluHi 9, divz 1; next add clears divz.
REQ-040 reset during div cycle 12 -> busy 0 immediately, outputs at reset values, no done; following and 0xF0 & 0x3C -> 0x30.
